led_pattern_gen: RTL

Parametrised front-panel LED pattern generator, the successor to the fixed 8-bit two-eye cylon. It drives a `WIDTH`-bit LED bank with a runtime-selectable pattern: one-eye cylon, two-eye cylon, binary count, blink, thermometer fill, all-on or all-off. The block has a programmable step rate, a freeze control and a power-on lamp test. It sits in the board-level utilities, fed by the 40 MHz system clock, with its output going straight to LED pads.

---
 rtl/led_pattern_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: front-panel LED pattern generator with programmable step
// rate, freeze control and a power-on lamp test.
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   rate   : step-rate select, accumulator increment is rate+1
//   mode   : pattern select (0 cylon1, 1 cylon2, 2 count, 3 blink, 4 fill,
//            5 all-on, 6/7 all-off)
//   freeze : holds prescaler and pattern
//   q      : registered LED drive
//   step   : registered one-cycle pulse on each pattern advance
module led_pattern_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MXPRE = 21,
    parameter int unsigned RATEW = 2,
    parameter int unsigned LAMP  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RATEW-1:0] rate,
    input  logic [2:0]       mode,
    input  logic             freeze,
    output logic [WIDTH-1:0] q,
    output logic             step
);

    localparam int unsigned HALF  = (WIDTH + 1) / 2;
    localparam int unsigned LAMPW = 16;
    localparam int unsigned ACCW  = MXPRE + 1;
    localparam logic [LAMPW-1:0] LAMP_INIT = LAMPW'(LAMP);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_LAMP = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LAMPW-1:0] lamp_q, lamp_d;
    logic [MXPRE-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [2:0]       mode_r_q, mode_r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             step_q, step_d;

    logic [ACCW-1:0]  sum_c;
    logic [WIDTH-1:0] adv_pos_c;
    logic             adv_dir_c;
    logic [WIDTH-1:0] lim_c;

    // LED image for a given mode and position/counter value
    function automatic logic [WIDTH-1:0] pattern(input logic [2:0] m,
                                                 input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (m)
                3'd0:    r[i] = (WIDTH'(i) == p);
                3'd1:    r[i] = (WIDTH'(i) == p) ||
                                (WIDTH'(i) == (WIDTH'(WIDTH - 1) - p));
                3'd2:    r[i] = p[i];
                3'd3:    r[i] = ~p[0];
                3'd4:    r[i] = (WIDTH'(i) < p);
                3'd5:    r[i] = 1'b1;
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Prescaler add; the carry-out is the advance strobe
    assign sum_c = {1'b0, acc_q} + ACCW'(rate) + ACCW'(1);

    // Upper endpoint of the bouncing modes
    always_comb begin
        lim_c = '0;
        case (mode_r_q)
            3'd0:    lim_c = WIDTH'(WIDTH - 1);
            3'd1:    lim_c = WIDTH'(HALF - 1);
            3'd4:    lim_c = WIDTH'(WIDTH);
            default: lim_c = '0;
        endcase
    end

    // Position/direction after one advance of the current mode
    always_comb begin
        adv_pos_c = pos_q;
        adv_dir_c = dir_q;
        case (mode_r_q)
            3'd0, 3'd1, 3'd4: begin
                // Direction flips on arriving at an endpoint, so no endpoint repeats
                if (dir_q == DIR_UP) begin
                    adv_pos_c = pos_q + WIDTH'(1);
                    if (adv_pos_c == lim_c) adv_dir_c = DIR_DOWN;
                end else begin
                    adv_pos_c = pos_q - WIDTH'(1);
                    if (adv_pos_c == '0) adv_dir_c = DIR_UP;
                end
            end
            3'd2:    adv_pos_c = pos_q + WIDTH'(1);
            3'd3:    adv_pos_c = pos_q ^ WIDTH'(1);
            default: adv_pos_c = pos_q;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        lamp_d   = lamp_q;
        acc_d    = acc_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        mode_r_d = mode_r_q;
        q_d      = q_q;
        step_d   = 1'b0;

        case (state_q)
            ST_LAMP: begin
                mode_r_d = mode;
                q_d      = '1;
                lamp_d   = lamp_q - LAMPW'(1);
                if (lamp_q == LAMPW'(1)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Prescaler is released only from the following edge
                mode_r_d = mode;
                acc_d    = '0;
                pos_d    = '0;
                dir_d    = DIR_UP;
                q_d      = pattern(mode, '0);
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (mode != mode_r_q) begin
                    // Mode change beats both advance and freeze
                    mode_r_d = mode;
                    acc_d    = '0;
                    pos_d    = '0;
                    dir_d    = DIR_UP;
                    q_d      = pattern(mode, '0);
                end else if (!freeze) begin
                    acc_d = sum_c[MXPRE-1:0];
                    if (sum_c[MXPRE]) begin
                        pos_d  = adv_pos_c;
                        dir_d  = adv_dir_c;
                        q_d    = pattern(mode_r_q, adv_pos_c);
                        step_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_LAMP;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_LAMP;
            lamp_q   <= LAMP_INIT;
            acc_q    <= '0;
            pos_q    <= '0;
            dir_q    <= DIR_UP;
            mode_r_q <= mode;
            q_q      <= '1;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lamp_q   <= lamp_d;
            acc_q    <= acc_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            mode_r_q <= mode_r_d;
            q_q      <= q_d;
            step_q   <= step_d;
        end
    end

    assign q    = q_q;
    assign step = step_q;

endmodule
